// File: rtl/bht_update_scheduler.sv
// Branch history table update scheduler: queues ROB branch outcomes and issues one saturating
// 2-bit counter write per cycle with forwarding; sweeps the table to INIT_VAL after reset/clear.
// Optional statistics counters are enabled with the BHT_STATS_EN macro.

module bht_update_scheduler #(
  parameter int         IDX_W      = 8,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] INIT_VAL   = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena_from_rob,
  input  logic             hit_from_rob,
  input  logic [31:0]      pc_from_rob,
  output logic             rdy_to_rob,
  input  logic             clear_req,
  output logic [IDX_W-1:0] rd_idx,
  input  logic [1:0]       rd_val,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_idx,
  output logic [1:0]       wr_val,
  output logic             busy,
  output logic [15:0]      stat_upd,
  output logic [15:0]      stat_drop
);

  localparam int               PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]   DEPTH_C    = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] SWEEP_LAST = {IDX_W{1'b1}};

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] sweep_cnt, sweep_nxt;
  logic [IDX_W-1:0] q_idx [FIFO_DEPTH];
  logic             q_hit [FIFO_DEPTH];
  logic [PTR_W-1:0] head_ptr, tail_ptr;
  logic [PTR_W:0]   count;
  logic             wr_en_nxt;
  logic [IDX_W-1:0] wr_idx_nxt;
  logic [1:0]       wr_val_nxt;
  logic             run_ok, push, pop, drop, head_hit;
  logic [1:0]       src_val, new_val;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{pc_from_rob[31:IDX_W+2], pc_from_rob[1:0]};
  assign rdy_to_rob     = (count < DEPTH_C);
  assign rd_idx         = q_idx[head_ptr];
  assign head_hit       = q_hit[head_ptr];
  assign busy           = (state == S_CLEAR);

  // The table read is one write behind, so an in-flight write to the same entry takes priority.
  always_comb begin
    src_val = rd_val;
    if (wr_en && (wr_idx == rd_idx)) begin
      src_val = wr_val;
    end
    new_val = src_val;
    if (head_hit) begin
      if (src_val != 2'b11) begin
        new_val = src_val + 2'b01;
      end
    end else begin
      if (src_val != 2'b00) begin
        new_val = src_val - 2'b01;
      end
    end
  end

  always_comb begin
    run_ok = (state == S_RUN) && !clear_req;
    push   = run_ok && ena_from_rob && rdy_to_rob;
    pop    = run_ok && (count != '0);
    drop   = run_ok && ena_from_rob && !rdy_to_rob;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        q_idx[i] <= '0;
        q_hit[i] <= 1'b0;
      end
    end else if (push) begin
      q_idx[tail_ptr] <= pc_from_rob[IDX_W+1:2];
      q_hit[tail_ptr] <= hit_from_rob;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (clear_req) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        tail_ptr <= tail_ptr + PTR_W'(1);
      end
      if (pop) begin
        head_ptr <= head_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + (PTR_W+1)'(1);
      end else if (pop && !push) begin
        count <= count - (PTR_W+1)'(1);
      end
    end
  end

  // A clear request always drops the next write slot and restarts the sweep from index 0.
  always_comb begin
    state_nxt  = state;
    sweep_nxt  = sweep_cnt;
    wr_en_nxt  = 1'b0;
    wr_idx_nxt = wr_idx;
    wr_val_nxt = wr_val;
    case (state)
      S_CLEAR: begin
        if (clear_req) begin
          sweep_nxt = '0;
        end else begin
          wr_en_nxt  = 1'b1;
          wr_idx_nxt = sweep_cnt;
          wr_val_nxt = INIT_VAL;
          sweep_nxt  = sweep_cnt + IDX_W'(1);
          if (sweep_cnt == SWEEP_LAST) begin
            state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (clear_req) begin
          state_nxt = S_CLEAR;
          sweep_nxt = '0;
        end else if (pop) begin
          wr_en_nxt  = 1'b1;
          wr_idx_nxt = rd_idx;
          wr_val_nxt = new_val;
        end
      end
      default: begin
        state_nxt = S_CLEAR;
        sweep_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_CLEAR;
      sweep_cnt <= '0;
      wr_en     <= 1'b0;
      wr_idx    <= '0;
      wr_val    <= 2'b00;
    end else begin
      state     <= state_nxt;
      sweep_cnt <= sweep_nxt;
      wr_en     <= wr_en_nxt;
      wr_idx    <= wr_idx_nxt;
      wr_val    <= wr_val_nxt;
    end
  end

`ifdef BHT_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_upd  <= '0;
      stat_drop <= '0;
    end else if (clear_req) begin
      stat_upd  <= '0;
      stat_drop <= '0;
    end else begin
      if (pop && (stat_upd != 16'hFFFF)) begin
        stat_upd <= stat_upd + 16'd1;
      end
      if (drop && (stat_drop != 16'hFFFF)) begin
        stat_drop <= stat_drop + 16'd1;
      end
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
  assign stat_upd    = 16'd0;
  assign stat_drop   = 16'd0;
`endif

endmodule

// File: tb/tb_bht_update_scheduler.sv
// Self-checking bench for bht_update_scheduler: a behavioural BHT stub plus a queue/array
// reference model of the update stream, driven by directed and $urandom traffic.

module tb_bht_update_scheduler;

  localparam int IDX_W   = 8;
  localparam int DEPTH   = 4;
  localparam int ENTRIES = 256;

  logic             clk = 1'b0;
  logic             rst;
  logic             ena_from_rob;
  logic             hit_from_rob;
  logic [31:0]      pc_from_rob;
  logic             rdy_to_rob;
  logic             clear_req;
  logic [IDX_W-1:0] rd_idx;
  logic [1:0]       rd_val;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       wr_val;
  logic             busy;
  logic [15:0]      stat_upd;
  logic [15:0]      stat_drop;

  logic [1:0] bht_mem [ENTRIES];
  int         model_bht [ENTRIES];
  int         exp_upd;
  int         exp_drop;
  int         checks = 0;
  int         fails  = 0;

  bht_update_scheduler #(.IDX_W(IDX_W), .FIFO_DEPTH(DEPTH), .INIT_VAL(2'b01)) dut (
    .clk(clk), .rst(rst), .ena_from_rob(ena_from_rob), .hit_from_rob(hit_from_rob),
    .pc_from_rob(pc_from_rob), .rdy_to_rob(rdy_to_rob), .clear_req(clear_req),
    .rd_idx(rd_idx), .rd_val(rd_val), .wr_en(wr_en), .wr_idx(wr_idx), .wr_val(wr_val),
    .busy(busy), .stat_upd(stat_upd), .stat_drop(stat_drop)
  );

  always #5 clk = ~clk;

  // Behavioural BHT: combinational read, write lands one edge after the strobe is registered.
  always @(posedge clk) if (wr_en) bht_mem[wr_idx] <= wr_val;
  assign rd_val = bht_mem[rd_idx];

  task automatic test_reset();
    rst = 1'b0; ena_from_rob = 1'b0; hit_from_rob = 1'b0; pc_from_rob = '0; clear_req = 1'b0;
    #12;
    checks++;
    if ({wr_en, wr_idx, wr_val} !== 11'b0)
      begin fails++; $display("[TB] FAIL reset_wr: got %b/%0h/%b expected 0/0/0", wr_en, wr_idx, wr_val); end
    checks++;
    if ({busy, rdy_to_rob} !== 2'b11)
      begin fails++; $display("[TB] FAIL reset_busy_rdy: got %b%b expected 11", busy, rdy_to_rob); end
    checks++;
    if ({stat_upd, stat_drop} !== 32'd0)
      begin fails++; $display("[TB] FAIL reset_stats: got %0d/%0d expected 0/0", stat_upd, stat_drop); end
    @(posedge clk); #1;
    rst = 1'b1;
    exp_upd = 0; exp_drop = 0;
  endtask

  task automatic test_sweep(input bit with_traffic);
    for (int i = 0; i < ENTRIES; i++) begin
      if (with_traffic) begin
        ena_from_rob = 1'($urandom_range(0, 1));
        hit_from_rob = 1'($urandom_range(0, 1));
        pc_from_rob  = $urandom();
      end
      @(posedge clk); #1;
      checks++;
      if ({wr_en, wr_idx, wr_val} !== {1'b1, 8'(i), 2'b01})
        begin fails++; $display("[TB] FAIL sweep_write: got %b/%0h/%b expected 1/%0h/01", wr_en, wr_idx, wr_val, i); end
      checks++;
      if (busy !== (i != ENTRIES - 1))
        begin fails++; $display("[TB] FAIL sweep_busy at %0d: got %b expected %b", i, busy, (i != ENTRIES - 1)); end
      checks++;
      if (rdy_to_rob !== 1'b1)
        begin fails++; $display("[TB] FAIL sweep_rdy at %0d: got %b expected 1", i, rdy_to_rob); end
    end
    ena_from_rob = 1'b0;
    for (int k = 0; k < ENTRIES; k++) model_bht[k] = 1;
    @(posedge clk); #1;
    checks++;
    if ({wr_en, busy} !== 2'b00)
      begin fails++; $display("[TB] FAIL sweep_end: got wr_en=%b busy=%b expected 0/0", wr_en, busy); end
  endtask

  task automatic test_directed();
    int hits [7] = '{1, 1, 1, 0, 0, 0, 0};
    int exps [7] = '{2, 3, 3, 2, 1, 0, 0};
    ena_from_rob = 1'b1; hit_from_rob = 1'b1; pc_from_rob = 32'h0000_0104;
    @(posedge clk); #1;
    ena_from_rob = 1'b0;
    checks++;
    if (wr_en !== 1'b0)
      begin fails++; $display("[TB] FAIL first_latency: got wr_en=%b expected 0", wr_en); end
    @(posedge clk); #1;
    checks++;
    if ({wr_en, wr_idx, wr_val} !== {1'b1, 8'h41, 2'b10})
      begin fails++; $display("[TB] FAIL first_update: got %b/%0h/%b expected 1/41/10", wr_en, wr_idx, wr_val); end
    model_bht[8'h41] = 2; exp_upd++;
    for (int i = 0; i < 8; i++) begin
      if (i < 7) begin
        ena_from_rob = 1'b1; pc_from_rob = 32'h0000_0100; hit_from_rob = 1'(hits[i]);
      end else begin
        ena_from_rob = 1'b0;
      end
      @(posedge clk); #1;
      if (i > 0) begin
        checks++;
        if ({wr_en, wr_idx, wr_val} !== {1'b1, 8'h40, 2'(exps[i-1])})
          begin fails++; $display("[TB] FAIL saturate_seq[%0d]: got %b/%0h/%0d expected 1/40/%0d", i-1, wr_en, wr_idx, wr_val, exps[i-1]); end
        exp_upd++;
      end
    end
    @(posedge clk); #1;
    model_bht[8'h40] = 0;
    checks++;
    if ({wr_en, bht_mem[8'h40]} !== 3'b000)
      begin fails++; $display("[TB] FAIL directed_drain: got wr_en=%b mem=%0d expected 0/0", wr_en, bht_mem[8'h40]); end
  endtask

  task automatic test_traffic(input int n, input int density);
    int q[$];
    int pre, code, idx, idx2, v;
    bit en, h, acc;
    logic [31:0] pcv;
    for (int c = 0; c < n + 2; c++) begin
      en  = (c < n) && ($urandom_range(0, 9) < density);
      h   = 1'($urandom_range(0, 1));
      idx = $urandom_range(8'h20, 8'h27);
      pcv = $urandom();
      pcv[9:2] = 8'(idx);
      ena_from_rob = en; hit_from_rob = h; pc_from_rob = pcv;
      pre = q.size();
      acc = en && (pre < DEPTH);
      if (en && !acc) exp_drop++;
      @(posedge clk); #1;
      if (pre > 0) begin
        code = q.pop_front();
        idx2 = code >> 1;
        v = model_bht[idx2];
        if (code % 2 == 1) v = (v < 3) ? v + 1 : 3;
        else               v = (v > 0) ? v - 1 : 0;
        model_bht[idx2] = v;
        exp_upd++;
        checks++;
        if ({wr_en, wr_idx, wr_val} !== {1'b1, 8'(idx2), 2'(v)})
          begin fails++; $display("[TB] FAIL traffic_write: got %b/%0h/%0d expected 1/%0h/%0d", wr_en, wr_idx, wr_val, idx2, v); end
      end else begin
        checks++;
        if (wr_en !== 1'b0)
          begin fails++; $display("[TB] FAIL traffic_idle: got wr_en=%b expected 0", wr_en); end
      end
      if (acc) q.push_back(idx * 2 + int'(h));
      checks++;
      if (rdy_to_rob !== (q.size() < DEPTH))
        begin fails++; $display("[TB] FAIL traffic_rdy: got %b expected %b", rdy_to_rob, (q.size() < DEPTH)); end
    end
    ena_from_rob = 1'b0;
  endtask

  task automatic test_stats();
    int eu, ed;
`ifdef BHT_STATS_EN
    eu = (exp_upd > 65535) ? 65535 : exp_upd;
    ed = (exp_drop > 65535) ? 65535 : exp_drop;
`else
    eu = 0;
    ed = 0;
`endif
    checks++;
    if (stat_upd !== 16'(eu))
      begin fails++; $display("[TB] FAIL stat_upd: got %0d expected %0d", stat_upd, eu); end
    checks++;
    if (stat_drop !== 16'(ed))
      begin fails++; $display("[TB] FAIL stat_drop: got %0d expected %0d", stat_drop, ed); end
  endtask

  task automatic test_burst();
    test_traffic(6, 10);
    test_stats();
  endtask

  task automatic test_clear();
    int va, vb, bad;
    va = (model_bht[8'h30] < 3) ? model_bht[8'h30] + 1 : 3;
    vb = (model_bht[8'h31] > 0) ? model_bht[8'h31] - 1 : 0;
    ena_from_rob = 1'b1; hit_from_rob = 1'b1; pc_from_rob = 32'h0000_00C0;
    @(posedge clk); #1;
    checks++;
    if (wr_en !== 1'b0)
      begin fails++; $display("[TB] FAIL clear_pre0: got wr_en=%b expected 0", wr_en); end
    hit_from_rob = 1'b0; pc_from_rob = 32'h0000_00C4;
    @(posedge clk); #1;
    checks++;
    if ({wr_en, wr_idx, wr_val} !== {1'b1, 8'h30, 2'(va)})
      begin fails++; $display("[TB] FAIL clear_pre1: got %b/%0h/%0d expected 1/30/%0d", wr_en, wr_idx, wr_val, va); end
    hit_from_rob = 1'b1; pc_from_rob = 32'h0000_00C8;
    @(posedge clk); #1;
    checks++;
    if ({wr_en, wr_idx, wr_val} !== {1'b1, 8'h31, 2'(vb)})
      begin fails++; $display("[TB] FAIL clear_pre2: got %b/%0h/%0d expected 1/31/%0d", wr_en, wr_idx, wr_val, vb); end
    clear_req = 1'b1; pc_from_rob = 32'h0000_00CC;
    @(posedge clk); #1;
    clear_req = 1'b0; ena_from_rob = 1'b0;
    exp_upd = 0; exp_drop = 0;
    checks++;
    if ({wr_en, busy, rdy_to_rob} !== 3'b011)
      begin fails++; $display("[TB] FAIL clear_edge: got wr_en=%b busy=%b rdy=%b expected 0/1/1", wr_en, busy, rdy_to_rob); end
    checks++;
    if ({stat_upd, stat_drop} !== 32'd0)
      begin fails++; $display("[TB] FAIL clear_stats: got %0d/%0d expected 0/0", stat_upd, stat_drop); end
    test_sweep(1'b1);
    bad = 0;
    for (int k = 0; k < ENTRIES; k++) if (bht_mem[k] !== 2'b01) bad++;
    checks++;
    if (bad != 0)
      begin fails++; $display("[TB] FAIL clear_table: got %0d entries not 01 expected 0", bad); end
  endtask

  task automatic test_reset_mid();
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    exp_upd = 0; exp_drop = 0;
    checks++;
    if ({busy, wr_en} !== 2'b10)
      begin fails++; $display("[TB] FAIL mid_clear: got busy=%b wr_en=%b expected 1/0", busy, wr_en); end
    for (int i = 0; i <= 8'h80; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({wr_en, wr_idx} !== {1'b1, 8'(i)})
        begin fails++; $display("[TB] FAIL mid_sweep: got %b/%0h expected 1/%0h", wr_en, wr_idx, i); end
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({wr_en, wr_idx, wr_val, busy, rdy_to_rob} !== {11'b0, 2'b11})
      begin fails++; $display("[TB] FAIL mid_reset: got %b/%0h/%b/%b/%b expected 0/0/00/1/1", wr_en, wr_idx, wr_val, busy, rdy_to_rob); end
    checks++;
    if ({stat_upd, stat_drop} !== 32'd0)
      begin fails++; $display("[TB] FAIL mid_reset_stats: got %0d/%0d expected 0/0", stat_upd, stat_drop); end
    #2;
    rst = 1'b1;
    test_sweep(1'b0);
  endtask

  initial begin
    test_reset();
    test_sweep(1'b0);
    test_directed();
    test_traffic(300, 7);
    test_stats();
    test_burst();
    test_clear();
    test_stats();
    test_traffic(100, 5);
    test_reset_mid();
    test_traffic(50, 8);
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
